// File: rtl/yarvi_muldiv_if.sv
// Request/response bundle between the EX stage (master) and the iterative M-extension unit (slave).
interface yarvi_muldiv_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic            req_w;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic [4:0]      req_rd;
  logic            kill;
  logic            resp_valid;
  logic [XLEN-1:0] resp_val;
  logic [4:0]      resp_rd;

  modport master (
    output req_valid, req_funct3, req_w, req_rs1, req_rs2, req_rd, kill,
    input  req_ready, resp_valid, resp_val, resp_rd
  );

  modport slave (
    input  req_valid, req_funct3, req_w, req_rs1, req_rs2, req_rd, kill,
    output req_ready, resp_valid, resp_val, resp_rd
  );
endinterface

// File: rtl/yarvi_muldiv.sv
// Iterative radix-2 RISC-V M-extension unit: shift-add multiply, restoring divide,
// word (OP_32) forms for XLEN=64, and early-out handling of divide special cases.
module yarvi_muldiv #(
  parameter int XLEN = 64
) (
  input  logic             clock,
  input  logic             reset,
  yarvi_muldiv_if.slave    bus,
  output logic [1:0]       dbg_state
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  // Handshake: a request is taken at a posedge where req_valid & req_ready (IDLE only)
  // and kill is low; the result appears for exactly one cycle with resp_valid, no backpressure.
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     n_last;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] mcand;
  logic [XLEN-1:0]   mplier;
  logic [XLEN:0]     rem;
  logic [XLEN-1:0]   divisor;
  logic              op_div, op_rem, op_high, op_word, neg_res, neg_rem;
  logic [4:0]        rd_q, rd_out;
  logic [XLEN-1:0]   res_q;

  logic [2:0]      d_f3;
  logic            d_word, d_sgn1, d_sgn2, d_sext, d_neg1, d_neg2;
  logic            d_div, d_zero, d_ovf, d_special;
  logic [XLEN-1:0] d_op1, d_op2, d_mag1, d_mag2;

  always_comb begin
    d_word = (XLEN == 64) && bus.req_w;
    d_f3   = bus.req_funct3;
    if (d_word && (d_f3 != 3'd0) && !d_f3[2]) d_f3 = 3'd0;
    d_div  = d_f3[2];
    d_sgn1 = (d_f3 == 3'd1) || (d_f3 == 3'd2) || (d_f3 == 3'd4) || (d_f3 == 3'd6);
    d_sgn2 = (d_f3 == 3'd1) || (d_f3 == 3'd4) || (d_f3 == 3'd6);
    d_sext = (d_f3 == 3'd0) || (d_f3 == 3'd4) || (d_f3 == 3'd6);
    if (d_word) begin
      d_op1 = d_sext ? XLEN'($signed(bus.req_rs1[31:0])) : XLEN'(bus.req_rs1[31:0]);
      d_op2 = d_sext ? XLEN'($signed(bus.req_rs2[31:0])) : XLEN'(bus.req_rs2[31:0]);
    end else begin
      d_op1 = bus.req_rs1;
      d_op2 = bus.req_rs2;
    end
    d_neg1 = d_sgn1 && d_op1[XLEN-1];
    d_neg2 = d_sgn2 && d_op2[XLEN-1];
    d_mag1 = d_neg1 ? -d_op1 : d_op1;
    d_mag2 = d_neg2 ? -d_op2 : d_op2;
    d_zero = d_word ? (bus.req_rs2[31:0] == 32'd0) : (bus.req_rs2 == '0);
    if (d_word)
      d_ovf = (bus.req_rs1[31:0] == 32'h8000_0000) && (bus.req_rs2[31:0] == 32'hFFFF_FFFF);
    else
      d_ovf = (d_op1 == {1'b1, {(XLEN-1){1'b0}}}) && (&d_op2);
    d_ovf     = d_ovf && ((d_f3 == 3'd4) || (d_f3 == 3'd6));
    d_special = d_div && (d_zero || d_ovf);
  end

  logic [2*XLEN-1:0] acc_nxt;
  logic              div_bit;
  logic [XLEN:0]     rem_sh, rem_diff;

  always_comb begin
    acc_nxt  = mplier[0] ? acc + mcand : acc;
    div_bit  = op_word ? mplier[31] : mplier[XLEN-1];
    rem_sh   = {rem[XLEN-1:0], div_bit};
    rem_diff = rem_sh - {1'b0, divisor};
  end

  // Signs were stripped at accept; re-apply them here on the final magnitudes.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmag, raw, done_val;

  always_comb begin
    prod = neg_res ? -acc : acc;
    quo  = neg_res ? -mplier : mplier;
    rmag = neg_rem ? -rem[XLEN-1:0] : rem[XLEN-1:0];
    if (op_div)
      raw = op_rem ? rmag : quo;
    else
      raw = op_high ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    done_val = op_word ? XLEN'($signed(raw[31:0])) : raw;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      n_last  <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      divisor <= '0;
      op_div  <= 1'b0;
      op_rem  <= 1'b0;
      op_high <= 1'b0;
      op_word <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      rd_q    <= '0;
      rd_out  <= '0;
      res_q   <= '0;
    end else if (bus.kill) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cnt     <= '0;
            n_last  <= d_word ? CW'(31) : CW'(XLEN-1);
            op_div  <= d_div;
            op_rem  <= d_f3[1];
            op_high <= !d_div && (d_f3[1:0] != 2'd0);
            op_word <= d_word;
            rd_q    <= bus.req_rd;
            acc     <= '0;
            mcand   <= (2*XLEN)'(d_mag1);
            divisor <= d_mag2;
            if (d_special) begin
              // Results are preloaded with no sign fix-up so DONE passes them through.
              neg_res <= 1'b0;
              neg_rem <= 1'b0;
              mplier  <= d_zero ? '1 : d_op1;
              rem     <= d_zero ? {1'b0, d_op1} : '0;
              state   <= DONE;
            end else begin
              neg_res <= d_neg1 ^ d_neg2;
              neg_rem <= d_neg1;
              mplier  <= d_div ? d_mag1 : d_mag2;
              rem     <= '0;
              state   <= RUN;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (op_div) begin
            rem    <= rem_diff[XLEN] ? rem_sh : rem_diff;
            mplier <= {mplier[XLEN-2:0], ~rem_diff[XLEN]};
          end else begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
          if (cnt == n_last) state <= DONE;
        end
        DONE: begin
          res_q  <= done_val;
          rd_out <= rd_q;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == DONE) && !bus.kill;
  assign bus.resp_val   = (state == DONE) ? done_val : res_q;
  assign bus.resp_rd    = (state == DONE) ? rd_q : rd_out;
  assign dbg_state      = state;
endmodule

// File: tb/tb_yarvi_muldiv.sv
// Directed bench for yarvi_muldiv: XLEN=64 and XLEN=32 instances, hand-computed results,
// latency, kill/reset abort and back-to-back throughput.
module tb_yarvi_muldiv;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  yarvi_muldiv_if #(.XLEN(64)) b64 ();
  yarvi_muldiv_if #(.XLEN(32)) b32 ();
  logic [1:0] st64, st32;

  yarvi_muldiv #(.XLEN(64)) dut64 (.clock(clock), .reset(reset), .bus(b64), .dbg_state(st64));
  yarvi_muldiv #(.XLEN(32)) dut32 (.clock(clock), .reset(reset), .bus(b32), .dbg_state(st32));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int resp64 = 0;
  int acc32 = 0;
  int acc_cyc[$];
  logic [63:0] exp_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (b64.resp_valid) resp64 <= resp64 + 1;
    if (b32.req_valid && b32.req_ready && !b32.kill) begin
      acc32 <= acc32 + 1;
      acc_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? b32.req_ready : b64.req_ready;
  endfunction

  function automatic logic rvalid(input bit sel);
    return sel ? b32.resp_valid : b64.resp_valid;
  endfunction

  function automatic logic [63:0] rval(input bit sel);
    return sel ? {32'd0, b32.resp_val} : b64.resp_val;
  endfunction

  function automatic logic [63:0] rrd(input bit sel);
    return sel ? 64'(b32.resp_rd) : 64'(b64.resp_rd);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit sel, input logic [2:0] f3, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    if (sel) begin
      b32.req_funct3 = f3; b32.req_w = w; b32.req_rs1 = a[31:0]; b32.req_rs2 = b[31:0];
      b32.req_rd = rd; b32.req_valid = 1'b1;
    end else begin
      b64.req_funct3 = f3; b64.req_w = w; b64.req_rs1 = a; b64.req_rs2 = b;
      b64.req_rd = rd; b64.req_valid = 1'b1;
    end
  endtask

  task automatic release_req(input bit sel);
    if (sel) b32.req_valid = 1'b0;
    else     b64.req_valid = 1'b0;
  endtask

  task automatic run_op(input bit sel, input string tag, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp, input int exp_lat);
    int n = 0;
    int lat = 1;
    while (!rdy(sel) && n < 200) begin step(); n++; end
    drive(sel, f3, w, a, b, rd);
    step();
    release_req(sel);
    while (!rvalid(sel) && lat < 200) begin step(); lat++; end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_val"}, rval(sel), exp);
    check({tag, "_rd"}, rrd(sel), 64'(rd));
    step();
  endtask

  // Issue DIV 100/7 on the 64-bit unit and return at RUN-cycle c_stop.
  task automatic start_div_to(input int c_stop);
    int c = 1;
    drive(1'b0, 3'd4, 1'b0, 64'd100, 64'd7, 5'd3);
    step();
    release_req(1'b0);
    while (c < c_stop) begin step(); c++; end
  endtask

  initial begin
    int r0;
    int a0;
    int n;
    reset = 1'b1;
    b64.req_valid = 0; b64.req_funct3 = 0; b64.req_w = 0; b64.req_rs1 = 0; b64.req_rs2 = 0;
    b64.req_rd = 0; b64.kill = 0;
    b32.req_valid = 0; b32.req_funct3 = 0; b32.req_w = 0; b32.req_rs1 = 0; b32.req_rs2 = 0;
    b32.req_rd = 0; b32.kill = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    check("rst_ready64", 64'(b64.req_ready), 64'd1);
    check("rst_rvalid64", 64'(b64.resp_valid), 64'd0);
    check("rst_rval64", b64.resp_val, 64'd0);
    check("rst_rrd64", 64'(b64.resp_rd), 64'd0);
    check("rst_state64", 64'(st64), 64'd0);
    check("rst_ready32", 64'(b32.req_ready), 64'd1);

    run_op(0, "mul",    3'd0, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    run_op(0, "mulhu",  3'd3, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6,
           64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op(0, "mulhsu", 3'd2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op(0, "div",    3'd4, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op(0, "rem",    3'd6, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op(0, "div0",   3'd4, 0, 64'd5, 64'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op(0, "remu0",  3'd7, 0, 64'd5, 64'd0, 5'd11, 64'd5, 1);
    run_op(0, "divovf", 3'd4, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12,
           64'h8000_0000_0000_0000, 1);
    run_op(0, "removf", 3'd6, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 64'd0, 1);
    run_op(0, "divw",   3'd4, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd14, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_op(0, "remw",   3'd6, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd15, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op(0, "divuw",  3'd5, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd16, 64'h0000_0000_7FFF_FFFC, 33);
    run_op(0, "mulhw",  3'd1, 1, 64'h0000_0000_FFFF_FFFF, 64'd2, 5'd17, 64'hFFFF_FFFF_FFFF_FFFE, 33);

    // kill in RUN cycle 10
    r0 = resp64;
    start_div_to(10);
    check("kill_run_state", 64'(st64), 64'd1);
    b64.kill = 1'b1;
    step();
    b64.kill = 1'b0;
    check("kill_run_ready", 64'(b64.req_ready), 64'd1);
    check("kill_run_idle", 64'(st64), 64'd0);
    repeat (80) step();
    check("kill_run_noresp", 64'(resp64), 64'(r0));
    run_op(0, "mul_after_kill", 3'd0, 0, 64'd3, 64'd4, 5'd20, 64'd12, 65);

    // kill coinciding with DONE
    r0 = resp64;
    start_div_to(65);
    check("kill_done_state", 64'(st64), 64'd2);
    b64.kill = 1'b1;
    #1;
    check("kill_done_rvalid", 64'(b64.resp_valid), 64'd0);
    step();
    b64.kill = 1'b0;
    check("kill_done_idle", 64'(st64), 64'd0);
    repeat (5) step();
    check("kill_done_noresp", 64'(resp64), 64'(r0));

    // reset mid-RUN
    r0 = resp64;
    start_div_to(20);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_run_idle", 64'(st64), 64'd0);
    check("rst_run_ready", 64'(b64.req_ready), 64'd1);
    check("rst_run_rval", b64.resp_val, 64'd0);
    repeat (80) step();
    check("rst_run_noresp", 64'(resp64), 64'(r0));

    // XLEN=32 instance; req_w must be ignored
    run_op(1, "div32",  3'd4, 1, 64'hFFFF_FFF9, 64'd2, 5'd21, 64'hFFFF_FFFD, 33);
    run_op(1, "rem32",  3'd6, 1, 64'hFFFF_FFF9, 64'd2, 5'd22, 64'hFFFF_FFFF, 33);
    run_op(1, "divu32", 3'd5, 0, 64'hFFFF_FFF9, 64'd2, 5'd23, 64'h7FFF_FFFC, 33);

    // back-to-back with valid held
    acc_cyc.delete();
    a0 = acc32;
    repeat (3) exp_q.push_back(64'hFFFF_FFFD);
    drive(1'b1, 3'd4, 1'b0, 64'hFFFF_FFF9, 64'd2, 5'd9);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      step();
      while (!b32.resp_valid && n < 100) begin step(); n++; end
      if (k == 2) release_req(1'b1);
      check($sformatf("b2b_val%0d", k), rval(1'b1), exp_q.pop_front());
    end
    repeat (3) step();
    check("b2b_accepts", 64'(acc32 - a0), 64'd3);
    if (acc_cyc.size() >= 3) begin
      check("b2b_gap0", 64'(acc_cyc[1] - acc_cyc[0]), 64'd34);
      check("b2b_gap1", 64'(acc_cyc[2] - acc_cyc[1]), 64'd34);
    end else begin
      check("b2b_acc_log", 64'(acc_cyc.size()), 64'd3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
